// File: rtl/vga_grid_renderer_if.sv
// vga_grid_renderer_if: game-side inputs and VGA pin outputs of the grid renderer.
interface vga_grid_renderer_if;
    logic       pix_ce;
    logic       in_game;
    logic       hit;
    logic [7:0] position;
    logic       o_hsync;
    logic       o_vsync;
    logic       o_de;
    logic       o_frame_start;
    logic [3:0] o_red;
    logic [3:0] o_green;
    logic [3:0] o_blue;
    modport master (
        output pix_ce, in_game, hit, position,
        input  o_hsync, o_vsync, o_de, o_frame_start, o_red, o_green, o_blue
    );
    modport slave (
        input  pix_ce, in_game, hit, position,
        output o_hsync, o_vsync, o_de, o_frame_start, o_red, o_green, o_blue
    );
endinterface

// File: rtl/vga_grid_renderer.sv
// vga_grid_renderer: VGA timing plus GRID_N x GRID_N whack-a-mole board with hit flash.
// Define GRID_LINES_EN to draw 2-pixel white lines on internal cell boundaries.
module vga_grid_renderer #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int SYNC_POL     = 0,
    parameter int GRID_N       = 3,
    parameter int MARGIN       = 16,
    parameter int FLASH_FRAMES = 30
) (
    input logic clk,
    input logic rst,
    vga_grid_renderer_if.slave bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int CELL_W = H_ACTIVE / GRID_N;
    localparam int CELL_H = V_ACTIVE / GRID_N;
    localparam logic POL = 1'(SYNC_POL);
    localparam logic [3:0] N = 4'(GRID_N);

    logic [HW-1:0] hcnt, cx;
    logic [VW-1:0] vcnt, cy;
    logic [3:0] col, row;
    logic [7:0] pos_q, flash_q, pos_c, flash_c;
    logic game_q, hit_q, game_c;
    logic h_end, v_end, frame0, active, in_grid, mole, line, hs, vs;
    logic [8:0] cell_idx;
    logic [11:0] rgb;

`ifdef GRID_LINES_EN
    assign line = in_grid && ((col != '0 && cx < HW'(2)) || (row != '0 && cy < VW'(2)));
`else
    assign line = 1'b0;
`endif

    // Frame-level state is taken straight from the inputs on the (0,0) tick so pixel 0 already sees it.
    always_comb begin
        h_end    = hcnt == HW'(H_TOTAL - 1);
        v_end    = vcnt == VW'(V_TOTAL - 1);
        frame0   = hcnt == '0 && vcnt == '0;
        pos_c    = frame0 ? bus.position : pos_q;
        game_c   = frame0 ? bus.in_game : game_q;
        flash_c  = !frame0 ? flash_q : (bus.hit && !hit_q) ? 8'(FLASH_FRAMES) : (flash_q != '0) ? flash_q - 8'd1 : '0;
        active   = hcnt < HW'(H_ACTIVE) && vcnt < VW'(V_ACTIVE);
        hs       = hcnt >= HW'(H_ACTIVE + H_FP) && hcnt < HW'(H_ACTIVE + H_FP + H_SYNC);
        vs       = vcnt >= VW'(V_ACTIVE + V_FP) && vcnt < VW'(V_ACTIVE + V_FP + V_SYNC);
        in_grid  = col != N && row != N;
        cell_idx = 9'(row) * 9'(GRID_N) + 9'(col) + 9'd1;
        mole     = in_grid && cell_idx == {1'b0, pos_c} &&
                   cx >= HW'(MARGIN) && cx < HW'(CELL_W - MARGIN) &&
                   cy >= VW'(MARGIN) && cy < VW'(CELL_H - MARGIN);
        rgb      = !active ? 12'h000 : !game_c ? 12'hFFF : mole ? (flash_c != '0 ? 12'hF00 : 12'h0F0) : line ? 12'hFFF : 12'h000;
    end

    // col/row saturate at GRID_N, marking pixels past the truncated grid as background.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt <= '0;
            vcnt <= '0;
            cx <= '0;
            cy <= '0;
            col <= '0;
            row <= '0;
            pos_q <= '0;
            flash_q <= '0;
            game_q <= 1'b0;
            hit_q <= 1'b0;
            bus.o_hsync <= ~POL;
            bus.o_vsync <= ~POL;
            bus.o_de <= 1'b0;
            bus.o_frame_start <= 1'b0;
            {bus.o_red, bus.o_green, bus.o_blue} <= '0;
        end else if (bus.pix_ce) begin
            hcnt <= h_end ? '0 : hcnt + 1'b1;
            vcnt <= h_end ? (v_end ? '0 : vcnt + 1'b1) : vcnt;
            cx <= (h_end || cx == HW'(CELL_W - 1)) ? '0 : cx + 1'b1;
            col <= h_end ? '0 : (cx == HW'(CELL_W - 1) && col != N) ? col + 1'b1 : col;
            cy <= h_end ? ((v_end || cy == VW'(CELL_H - 1)) ? '0 : cy + 1'b1) : cy;
            row <= (h_end && v_end) ? '0 : (h_end && cy == VW'(CELL_H - 1) && row != N) ? row + 1'b1 : row;
            pos_q <= pos_c;
            game_q <= game_c;
            flash_q <= flash_c;
            hit_q <= frame0 ? bus.hit : hit_q;
            bus.o_hsync <= hs ? POL : ~POL;
            bus.o_vsync <= vs ? POL : ~POL;
            bus.o_de <= active;
            bus.o_frame_start <= frame0;
            {bus.o_red, bus.o_green, bus.o_blue} <= rgb;
        end
    end
endmodule

// File: tb/tb_vga_grid_renderer.sv
// tb_vga_grid_renderer: scoreboard of every pixel plus table-driven probes and flash/reset sequences.
module tb_vga_grid_renderer;
    localparam int HA = 25, HF = 2, HS = 3, HB = 3;
    localparam int VA = 19, VF = 1, VS = 2, VB = 2;
    localparam int N = 3, M = 2, FL = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int CW = HA / N, CH = VA / N;
    localparam int LIM = 4 * HT * VT + 20;
    localparam int MOLE = 8 * HT + 10;

    typedef struct {
        logic       game;
        logic [7:0] pos;
        int         x;
        int         y;
        logic       de;
        logic [11:0] rgb;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    vga_grid_renderer_if bus();

    vga_grid_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .GRID_N(N), .MARGIN(M), .FLASH_FRAMES(FL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cur = 0;
    int mx = 0, my = 0;
    logic [7:0] mpos = '0, mfl = '0;
    logic mgame = 1'b0, mhit = 1'b0;
    logic [15:0] sb[$];
    vec_t tv[14];
    int k, n, cde, chs, cvs, cfs;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_px();
        return {bus.o_hsync, bus.o_vsync, bus.o_de, bus.o_frame_start, bus.o_red, bus.o_green, bus.o_blue};
    endfunction

    function automatic logic f0();
        return mx == 0 && my == 0;
    endfunction

    function automatic logic [7:0] fl_next();
        return (bus.hit && !mhit) ? 8'(FL) : (mfl != 0 ? mfl - 8'd1 : 8'd0);
    endfunction

    function automatic logic [15:0] expect_px(int x, int y, logic [7:0] pos, logic game, logic [7:0] fl);
        logic de, hs, vs, fs, mole;
        logic [11:0] rgb;
        int c, r, ox, oy;
        c = x / CW; r = y / CH; ox = x % CW; oy = y % CH;
        de = x < HA && y < VA;
        hs = !(x >= HA + HF && x < HA + HF + HS);
        vs = !(y >= VA + VF && y < VA + VF + VS);
        fs = x == 0 && y == 0;
        mole = c < N && r < N && int'(pos) == r * N + c + 1 && ox >= M && ox < CW - M && oy >= M && oy < CH - M;
        rgb = !de ? 12'h000 : !game ? 12'hFFF : mole ? (fl != 0 ? 12'hF00 : 12'h0F0) : 12'h000;
        return {hs, vs, de, fs, rgb};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mx <= 0;
            my <= 0;
            mpos <= '0;
            mfl <= '0;
            mgame <= 1'b0;
            mhit <= 1'b0;
            sb.delete();
        end else if (bus.pix_ce) begin
            sb.push_back(expect_px(mx, my, f0() ? bus.position : mpos, f0() ? bus.in_game : mgame, f0() ? fl_next() : mfl));
            if (f0()) begin
                mpos <= bus.position;
                mgame <= bus.in_game;
                mhit <= bus.hit;
                mfl <= fl_next();
            end
            if (mx == HT - 1) begin
                mx <= 0;
                my <= (my == VT - 1) ? 0 : my + 1;
            end else mx <= mx + 1;
        end
    end

    always @(negedge clk)
        while (sb.size() > 0) check("pixel", 32'(dut_px()), 32'(sb.pop_front()));

    initial begin
        bus.pix_ce = 1'b0;
        forever begin
            @(negedge clk);
            bus.pix_ce = ~bus.pix_ce;
        end
    end

    task automatic tick();
        do @(posedge clk); while (!bus.pix_ce);
        @(negedge clk);
    endtask

    task automatic wait_frame();
        int c = 0;
        while (bus.o_frame_start && c < LIM) begin @(negedge clk); c++; end
        while (!bus.o_frame_start && c < LIM) begin @(negedge clk); c++; end
        check("frame_start", 32'(bus.o_frame_start), 32'd1);
        cur = 0;
    endtask

    task automatic probe(int idx);
        repeat (idx - cur) tick();
        cur = idx;
    endtask

    task automatic drive(logic g, logic h, logic [7:0] p);
        bus.in_game = g;
        bus.hit = h;
        bus.position = p;
    endtask

    task automatic chk_mole(string name, logic [11:0] exp);
        probe(MOLE);
        check(name, 32'({bus.o_red, bus.o_green, bus.o_blue}), 32'(exp));
    endtask

    initial begin
        tv[0]  = '{1'b0, 8'd5,  0,  0, 1'b1, 12'hFFF};
        tv[1]  = '{1'b0, 8'd5, 24, 18, 1'b1, 12'hFFF};
        tv[2]  = '{1'b1, 8'd5,  9,  8, 1'b1, 12'h000};
        tv[3]  = '{1'b1, 8'd5, 10,  8, 1'b1, 12'h0F0};
        tv[4]  = '{1'b1, 8'd5, 14,  8, 1'b1, 12'h000};
        tv[5]  = '{1'b1, 8'd5, 25,  8, 1'b0, 12'h000};
        tv[6]  = '{1'b1, 8'd5, 13,  9, 1'b1, 12'h0F0};
        tv[7]  = '{1'b1, 8'd5, 10, 10, 1'b1, 12'h000};
        tv[8]  = '{1'b1, 8'd1,  2,  2, 1'b1, 12'h0F0};
        tv[9]  = '{1'b1, 8'd9, 21, 15, 1'b1, 12'h0F0};
        tv[10] = '{1'b1, 8'd9, 24, 15, 1'b1, 12'h000};
        tv[11] = '{1'b1, 8'd0, 10,  8, 1'b1, 12'h000};
        tv[12] = '{1'b1, 8'd10, 10, 8, 1'b1, 12'h000};
        tv[13] = '{1'b1, 8'd10, 2, 18, 1'b1, 12'h000};
        drive(1'b0, 1'b0, 8'd0);
        repeat (4) @(negedge clk);
        check("reset_state", 32'(dut_px()), 32'h0000C000);
        #2 rst = 1'b1;

        wait_frame();
        cde = 0; chs = 0; cvs = 0; cfs = 0;
        for (int i = 0; i < HT * VT; i++) begin
            if (i > 0) tick();
            cde += int'(bus.o_de);
            chs += int'(!bus.o_hsync);
            cvs += int'(!bus.o_vsync);
            cfs += int'(bus.o_frame_start);
        end
        tick();
        cur = 0;
        check("de_count", 32'(cde), 32'(HA * VA));
        check("hsync_low", 32'(chs), 32'(HS * VT));
        check("vsync_low", 32'(cvs), 32'(VS * HT));
        check("fs_count", 32'(cfs), 32'd1);
        check("frame_period", 32'(bus.o_frame_start), 32'd1);

        for (int i = 0; i < 14; i++) begin
            k = tv[i].y * HT + tv[i].x;
            if (i == 0 || tv[i].game != tv[i-1].game || tv[i].pos != tv[i-1].pos || k <= cur) begin
                drive(tv[i].game, 1'b0, tv[i].pos);
                wait_frame();
            end
            probe(k);
            check($sformatf("vec%0d", i), 32'({bus.o_de, bus.o_red, bus.o_green, bus.o_blue}), 32'({tv[i].de, tv[i].rgb}));
        end

        drive(1'b1, 1'b0, 8'd2);
        wait_frame();
        probe(2 * HT + 10);
        check("mid_old", 32'({bus.o_red, bus.o_green, bus.o_blue}), 32'h0F0);
        drive(1'b1, 1'b0, 8'd7);
        probe(14 * HT + 2);
        check("mid_keep", 32'({bus.o_red, bus.o_green, bus.o_blue}), 32'h000);
        wait_frame();
        probe(14 * HT + 2);
        check("mid_new", 32'({bus.o_red, bus.o_green, bus.o_blue}), 32'h0F0);

        drive(1'b1, 1'b0, 8'd5);
        wait_frame();
        drive(1'b1, 1'b1, 8'd5);
        wait_frame();
        drive(1'b1, 1'b0, 8'd5);
        chk_mole("flash_f0", 12'hF00);
        for (int f = 1; f <= FL; f++) begin
            wait_frame();
            chk_mole($sformatf("flash_f%0d", f), f < FL ? 12'hF00 : 12'h0F0);
        end

        drive(1'b1, 1'b1, 8'd5);
        for (int f = 0; f <= FL; f++) begin
            wait_frame();
            chk_mole($sformatf("level_f%0d", f), f < FL ? 12'hF00 : 12'h0F0);
        end
        drive(1'b1, 1'b0, 8'd5);
        wait_frame();

        drive(1'b1, 1'b1, 8'd5);
        wait_frame();
        drive(1'b1, 1'b0, 8'd5);
        chk_mole("retrig_a0", 12'hF00);
        wait_frame();
        chk_mole("retrig_a1", 12'hF00);
        drive(1'b1, 1'b1, 8'd5);
        wait_frame();
        drive(1'b1, 1'b0, 8'd5);
        for (int f = 0; f <= FL; f++) begin
            if (f > 0) wait_frame();
            chk_mole($sformatf("retrig_b%0d", f), f < FL ? 12'hF00 : 12'h0F0);
        end

        wait_frame();
        probe(10 * HT);
        #2 rst = 1'b0;
        #1 check("rst_async", 32'(dut_px()), 32'h0000C000);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.o_frame_start && n < LIM);
        check("fs_after_rst", 32'(n), 32'd1);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
